seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//   Parametrised multiplexed 7-segment driver for NUM_DIGITS hex digits on a
//   common-segment display. Time-scans digits with a programmable dwell,
//   inter-digit ghost blanking and tear-free frame-boundary updates. Sits
//   between a CPU/PIO value register and the board's segment/digit pins.
// PARAMETERS
//   NUM_DIGITS     4      digits scanned, 1..8
//   SCAN_DIV       12000  clk cycles per digit slot, >= 2
//   BLANK_CYC      16     cycles at slot start with all digits off, < SCAN_DIV
//   SEG_ACT_LOW    0      1 = invert seg_out at the pins
//   DIG_ACT_LOW    1      1 = dig_en active-low
// PORTS
//   clk         in   1             system clock, single clock domain
//   rst_n       in   1             asynchronous active-low reset
//   value       in   4*NUM_DIGITS  nibble i = digit i; digit 0 is rightmost
//   dp_in       in   NUM_DIGITS    decimal point per digit
//   load        in   1             capture value/dp_in into pending register
//   blank       in   1             force all digits off while high
//   seg_out     out  8             {dp,a,b,c,d,e,f,g}; 0 -> 7'h7E on bits[6:0]
//   dig_en      out  NUM_DIGITS    one-hot digit enable
//   frame_done  out  1             1-cycle pulse when the last slot ends
// BEHAVIOUR
//   Reset (async assert, sync release): div_cnt=0, idx=0, disp/pend regs=0,
//     pend_vld=0, frame_done=0, dig_en=all inactive, seg_out=all segments off
//     after polarity is applied.
//   load=1: pend <= {value,dp_in}, pend_vld <= 1. A later load overwrites.
//   div_cnt counts 0..SCAN_DIV-1 and then wraps. At the wrap, idx increments.
//     The idx wrap NUM_DIGITS-1 -> 0 is the frame boundary.
//   At the frame boundary: frame_done=1 for exactly that cycle. If pend_vld,
//     disp <= pend and pend_vld <= 0.
//   load coinciding with the boundary: the old pend commits, and the new data
//     becomes pend with pend_vld staying 1. The new data shows next frame.
//   seg_out and dig_en are registered. Their latency is 1 clk from the
//     idx/div_cnt state.
//   dig_en = onehot(idx) when div_cnt >= BLANK_CYC and blank=0, else all off.
//   seg_out = font(disp nibble[idx]) with bit7 = disp dp[idx]. It shows the
//     off pattern whenever dig_en is all off.
//   Font (bits[6:0]) for nibbles 0..F: 7E 30 6D 79 33 5B 5F 70 7F 7B 77 1F
//     4E 3D 4F 47.
//   NUM_DIGITS=1: idx stays 0, and every slot is a frame boundary.
//   blank does not stop the counters or frame_done.
//   Reset mid-scan returns to idx 0 and drops any pending load.
// CONFIGURATION
//   SEG7_LZB_EN defined: leading-zero blanking. Digits above the most
//     significant non-zero nibble of disp are driven as segments-off with
//     dig_en still active. dp is still shown. Digit 0 is never blanked, so the
//     value 0 shows "0". Blanking is evaluated on disp, never on pend.
//   SEG7_LZB_EN undefined: all digits are displayed, including leading zeros.
// STRUCTURE
//   Package seg7_pkg: SEG_OFF (8'h00), the 16-entry font constant array,
//     function seg7_font(nibble), and function onehot(idx, width).
//   Sub-module seg7_font_rom: combinational nibble -> 7-bit segment map,
//     instantiated once on the muxed nibble.
//   Top level: divider counter, digit index counter, pend/disp registers,
//     LZB mask logic, and the output registers with polarity.
// TESTING
//   1. Reset, then release. With NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2:
//      dig_en=4'b1111 (active-low) and seg_out=00 until cycle 3. Then
//      dig_en=4'b1110.
//   2. load value=16'h12AF once: no change until frame_done. In the next
//      frame, slots 0..3 show 47, 77, 6D, 30.
//   3. Two loads (16'h1111, then 16'h2222) within one frame: only 2222 is
//      displayed. load on the frame_done cycle: that value appears one frame
//      later.
//   4. blank=1 for a full frame: dig_en is all off and seg_out=00, while
//      frame_done still pulses every 4*8 cycles.
//   5. With SEG7_LZB_EN, value=16'h0050: digits 3 and 2 give seg_out=00, and
//      digits 1 and 0 give 5B and 7E. value=0 shows 7E on digit 0 only.
//   6. Assert rst_n low mid-slot 2 with a pending load: outputs reach reset
//      values immediately, and after release the display shows 0 with no
//      commit.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scan driver.
// Segment bit order is {dp,a,b,c,d,e,f,g}.
package seg7_pkg;

    localparam logic [7:0] SEG_OFF = 8'h00;

    localparam logic [6:0] FONT [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79,
        7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F,
        7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    function automatic logic [6:0] seg7_font(input logic [3:0] nib);
        return FONT[nib];
    endfunction

    function automatic logic [7:0] onehot(input logic [2:0] idx,
                                          input int width);
        logic [7:0] r;
        r = 8'h00;
        if (int'(idx) < width) r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/seg7_font_rom.sv
// Combinational hex nibble to 7-segment map (bits a..g).
module seg7_font_rom
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = seg7_font(nib);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex display driver with ghost blanking and frame-synced updates.
// Define SEG7_LZB_EN to enable leading-zero blanking.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int SCAN_DIV    = 12000,
    parameter int BLANK_CYC   = 16,
    parameter int SEG_ACT_LOW = 0,
    parameter int DIG_ACT_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    blank,
    output logic [7:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_done
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2(SCAN_DIV);

    localparam logic [7:0] SEG_INV = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_INV =
        (DIG_ACT_LOW != 0) ? '1 : '0;

    logic [CW-1:0]           div_cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] disp_val;
    logic [4*NUM_DIGITS-1:0] pend_val;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic                    pend_vld;

    logic                    slot_end;
    logic                    last_idx;
    logic                    boundary;
    logic                    dig_on;
    logic                    lz_blank;
    logic [3:0]              nib;
    logic                    cur_dp;
    logic [6:0]              font_seg;
    logic [7:0]              oh;
    logic [7:0]              seg_nxt;
    logic [NUM_DIGITS-1:0]   dig_nxt;

    assign slot_end   = (div_cnt == CW'(SCAN_DIV - 1));
    assign last_idx   = (idx == IW'(NUM_DIGITS - 1));
    assign boundary   = slot_end && last_idx;
    assign frame_done = boundary;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (slot_end) begin
            div_cnt <= '0;
            idx     <= last_idx ? '0 : idx + IW'(1);
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

    // Old pend commits at the boundary even when a new load lands on it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val <= '0;
            pend_dp  <= '0;
            pend_vld <= 1'b0;
            disp_val <= '0;
            disp_dp  <= '0;
        end else begin
            if (load) begin
                pend_val <= value;
                pend_dp  <= dp_in;
                pend_vld <= 1'b1;
            end else if (boundary) begin
                pend_vld <= 1'b0;
            end
            if (boundary && pend_vld) begin
                disp_val <= pend_val;
                disp_dp  <= pend_dp;
            end
        end
    end

    assign nib    = disp_val[4*int'(idx) +: 4];
    assign cur_dp = disp_dp[idx];

    seg7_font_rom u_font (
        .nib (nib),
        .seg (font_seg)
    );

`ifdef SEG7_LZB_EN
    logic [IW-1:0] msd;

    // Digit 0 can never sit above msd, so a zero value still shows "0".
    always_comb begin
        msd = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (disp_val[4*i +: 4] != 4'h0) msd = IW'(i);
        end
        lz_blank = (idx > msd);
    end
`else
    assign lz_blank = 1'b0;
`endif

    assign dig_on = (int'(div_cnt) >= BLANK_CYC) && !blank;
    assign oh     = onehot(3'(idx), NUM_DIGITS);

    always_comb begin
        seg_nxt = SEG_OFF;
        dig_nxt = '0;
        if (dig_on) begin
            seg_nxt = {cur_dp, lz_blank ? 7'h00 : font_seg};
            dig_nxt = oh[NUM_DIGITS-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out <= SEG_OFF ^ SEG_INV;
            dig_en  <= DIG_INV;
        end else begin
            seg_out <= seg_nxt ^ SEG_INV;
            dig_en  <= dig_nxt ^ DIG_INV;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver against a time-based display model.
// Honours SEG7_LZB_EN in its model when the design is built with it.
module tb_seg7_scan_driver;

    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int BLK   = 2;
    localparam int FRAME = N * DIV;

    logic          clk;
    logic          rst_n;
    logic [15:0]   value;
    logic [3:0]    dp_in;
    logic          load;
    logic          blank;
    logic [7:0]    seg_out;
    logic [3:0]    dig_en;
    logic          frame_done;

    int vectors     = 0;
    int miscompares = 0;

    int          t;
    logic [15:0] m_disp, m_pend;
    logic [3:0]  m_disp_dp, m_pend_dp;
    bit          m_vld;
    logic [7:0]  exp_seg;
    logic [3:0]  exp_dig;

    logic [6:0] font_t [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    seg7_scan_driver #(
        .NUM_DIGITS  (N),
        .SCAN_DIV    (DIV),
        .BLANK_CYC   (BLK),
        .SEG_ACT_LOW (0),
        .DIG_ACT_LOW (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .dp_in      (dp_in),
        .load       (load),
        .blank      (blank),
        .seg_out    (seg_out),
        .dig_en     (dig_en),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_seg(input int ix);
        logic [3:0] nb;
`ifdef SEG7_LZB_EN
        int msd;
        msd = 0;
        for (int i = 0; i < N; i++)
            if (m_disp[4*i +: 4] != 4'h0) msd = i;
        if (ix > msd) return {m_disp_dp[ix], 7'h00};
`endif
        nb = m_disp[4*ix +: 4];
        return {m_disp_dp[ix], font_t[nb]};
    endfunction

    task automatic model_reset();
        t         = 0;
        m_disp    = '0;
        m_pend    = '0;
        m_disp_dp = '0;
        m_pend_dp = '0;
        m_vld     = 1'b0;
        exp_seg   = 8'h00;
        exp_dig   = 4'hF;
    endtask

    // Called at a negedge: check, drive, advance model, one clock.
    task automatic step(input bit ld, input logic [15:0] v,
                        input logic [3:0] d, input bit bl);
        int pos, ix;
        bit on, bnd;
        chk("frame_done", 32'(frame_done), 32'((t % FRAME) == FRAME - 1));
        chk("dig_en", 32'(dig_en), 32'(exp_dig));
        chk("seg_out", 32'(seg_out), 32'(exp_seg));
        load  = ld;
        value = v;
        dp_in = d;
        blank = bl;
        pos = t % DIV;
        ix  = (t / DIV) % N;
        bnd = (t % FRAME) == FRAME - 1;
        on  = (pos >= BLK) && !bl;
        exp_dig = on ? ~(4'b0001 << ix) : 4'hF;
        exp_seg = on ? ref_seg(ix) : 8'h00;
        if (bnd && m_vld) begin
            m_disp    = m_pend;
            m_disp_dp = m_pend_dp;
            m_vld     = 1'b0;
        end
        if (ld) begin
            m_pend    = v;
            m_pend_dp = d;
            m_vld     = 1'b1;
        end
        t++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 16'h0, 4'h0, 0);
    endtask

    task automatic idle_to(input int fpos);
        while ((t % FRAME) != fpos) step(0, 16'h0, 4'h0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        load  = 1'b0;
        blank = 1'b0;
        value = '0;
        dp_in = '0;
        model_reset();
        #12;
        chk("rst_dig_en", 32'(dig_en), 32'h0000000F);
        chk("rst_seg_out", 32'(seg_out), 32'h0);
        chk("rst_frame_done", 32'(frame_done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        idle(40);

        idle_to(5);
        step(1, 16'h12AF, 4'h0, 0);
        idle(2 * FRAME);

        idle_to(3);
        step(1, 16'h1111, 4'h1, 0);
        idle_to(10);
        step(1, 16'h2222, 4'h2, 0);
        idle_to(FRAME - 1);
        step(1, 16'h3456, 4'h8, 0);
        idle(2 * FRAME + 4);

        for (int i = 0; i < FRAME + 8; i++) step(0, 16'h0, 4'h0, 1);

        idle_to(0);
        step(1, 16'h0050, 4'h0, 0);
        idle(2 * FRAME);
        step(1, 16'h0000, 4'h0, 0);
        idle(2 * FRAME);
        step(1, 16'h0A00, 4'hC, 0);
        idle(2 * FRAME);

        for (int i = 0; i < 2000; i++) begin
            logic [15:0] rv;
            rv = 16'($urandom);
            if ($urandom_range(0, 1) == 0) rv[15:8] = 8'h00;
            step($urandom_range(0, 15) == 0, rv, 4'($urandom),
                 $urandom_range(0, 7) == 0);
        end

        idle_to(2 * DIV + 1);
        step(1, 16'hBEEF, 4'hF, 0);
        idle(2);
        load = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_dig_en", 32'(dig_en), 32'h0000000F);
        chk("mid_rst_seg_out", 32'(seg_out), 32'h0);
        chk("mid_rst_frame_done", 32'(frame_done), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        idle(3 * FRAME);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
